dvsi_sensor_emu: RTL and testbench

- Emulates the DVS image sensor on the far end of the DVSI pad interface, so the PULPissimo DVSI readout path can be exercised on FPGA without a physical sensor.
- Consumes the control pins driven by the chip: asa, are, asy, ynrst, yclk, sxy, xclk, xnrst, cfg[7:0].
- Produces the pins the chip samples: xydata[7:0], on[3:0], off[3:0].
- Events come from a deterministic LFSR pattern generator whose density is set by cfg.

---
 rtl/dvsi_sensor_emu.sv | 139 +++++++++++++
 tb/tb_dvsi_sensor_emu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dvsi_sensor_emu.sv
// DVS image sensor emulator for the DVSI pad interface: tracks the row/column
// address pins and produces LFSR-driven ON/OFF events for the addressed pixel group.
module dvsi_sensor_emu #(
  parameter int          ROWS       = 64,
  parameter int          COL_GROUPS = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dvsi_asa_i,
  input  logic       dvsi_are_i,
  input  logic       dvsi_asy_i,
  input  logic       dvsi_ynrst_i,
  input  logic       dvsi_yclk_i,
  input  logic       dvsi_sxy_i,
  input  logic       dvsi_xclk_i,
  input  logic       dvsi_xnrst_i,
  input  logic [7:0] dvsi_cfg_i,
  output logic [7:0] dvsi_xydata_o,
  output logic [3:0] dvsi_on_o,
  output logic [3:0] dvsi_off_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [7:0]  ROW_LAST = 8'(ROWS - 1);
  localparam logic [7:0]  COL_LAST = 8'(COL_GROUPS - 1);
  // The active-low pointer resets idle high, so their sync stages reset to 1.
  localparam logic [15:0] SYNC_RST = 16'h0011;

  logic [15:0] pin_raw, sync_1, sync_2;
  logic [3:0]  edge_dly;
  logic        xnrst_s, xclk_s, sxy_s, yclk_s, ynrst_s, asy_s, are_s, asa_s;
  logic [7:0]  cfg_s;
  logic        x_rise, y_rise, asy_rise, are_rise;
  logic [7:0]  row, col;
  logic [15:0] frame_cnt;
  logic [15:0] lfsr, lfsr_next;
  logic [3:0]  on_c, off_c;
  logic [3:0]  on_thr, off_lim, nib;

  assign pin_raw = {dvsi_cfg_i, dvsi_asa_i, dvsi_are_i, dvsi_asy_i, dvsi_ynrst_i,
                    dvsi_yclk_i, dvsi_sxy_i, dvsi_xclk_i, dvsi_xnrst_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_1   <= SYNC_RST;
      sync_2   <= SYNC_RST;
      edge_dly <= '0;
    end else begin
      sync_1   <= pin_raw;
      sync_2   <= sync_1;
      edge_dly <= {are_s, asy_s, yclk_s, xclk_s};
    end
  end

  assign xnrst_s = sync_2[0];
  assign xclk_s  = sync_2[1];
  assign sxy_s   = sync_2[2];
  assign yclk_s  = sync_2[3];
  assign ynrst_s = sync_2[4];
  assign asy_s   = sync_2[5];
  assign are_s   = sync_2[6];
  assign asa_s   = sync_2[7];
  assign cfg_s   = sync_2[15:8];

  assign x_rise   = xclk_s & ~edge_dly[0];
  assign y_rise   = yclk_s & ~edge_dly[1];
  assign asy_rise = asy_s  & ~edge_dly[2];
  assign are_rise = are_s  & ~edge_dly[3];

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Address counters and frame count; array reset overrides both pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row       <= '0;
      col       <= '0;
      frame_cnt <= '0;
    end else if (are_rise) begin
      row <= '0;
      col <= '0;
    end else begin
      if (!ynrst_s) begin
        row <= '0;
      end else if (y_rise) begin
        if (row == ROW_LAST) begin
          row       <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          row <= row + 8'd1;
        end
      end
      if (!xnrst_s) begin
        col <= '0;
      end else if (x_rise) begin
        col <= (col == COL_LAST) ? 8'd0 : col + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr <= SEED;
    end else if (are_rise || asy_rise) begin
      lfsr <= SEED;
    end else if (x_rise && xnrst_s && asa_s) begin
      lfsr <= lfsr_next;
    end
  end

  // A nibble fires ON below the ON threshold, OFF within the top cfg[7:4] codes.
  always_comb begin
    on_c    = '0;
    off_c   = '0;
    nib     = '0;
    on_thr  = cfg_s[3:0];
    off_lim = 4'hF - cfg_s[7:4];
    for (int i = 0; i < 4; i++) begin
      nib      = lfsr[4*i +: 4];
      on_c[i]  = nib < on_thr;
      off_c[i] = !on_c[i] && (nib > off_lim);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvsi_on_o     <= '0;
      dvsi_off_o    <= '0;
      dvsi_xydata_o <= '0;
    end else begin
      dvsi_on_o     <= asa_s ? on_c  : 4'd0;
      dvsi_off_o    <= asa_s ? off_c : 4'd0;
      dvsi_xydata_o <= sxy_s ? col : row;
    end
  end

  assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_dvsi_sensor_emu.sv
// Directed bench for dvsi_sensor_emu: address counters, LFSR event pattern,
// reload/reset priorities and event suppression, against hand-computed values.
module tb_dvsi_sensor_emu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        asa, are, asy, ynrst, yclk, sxy, xclk, xnrst;
  logic [7:0]  cfg;
  logic [7:0]  xydata;
  logic [3:0]  on_o, off_o;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  dvsi_sensor_emu #(.ROWS(64), .COL_GROUPS(16), .SEED(16'hACE1)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dvsi_asa_i   (asa),
    .dvsi_are_i   (are),
    .dvsi_asy_i   (asy),
    .dvsi_ynrst_i (ynrst),
    .dvsi_yclk_i  (yclk),
    .dvsi_sxy_i   (sxy),
    .dvsi_xclk_i  (xclk),
    .dvsi_xnrst_i (xnrst),
    .dvsi_cfg_i   (cfg),
    .dvsi_xydata_o(xydata),
    .dvsi_on_o    (on_o),
    .dvsi_off_o   (off_o),
    .frame_cnt_o  (frame_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Raise the selected pins together, hold high 4 cycles and low 6 cycles.
  task automatic pulse(input logic do_x, input logic do_y, input logic do_are, input logic do_asy);
    @(negedge clk_i);
    xclk = do_x; yclk = do_y; are = do_are; asy = do_asy;
    wait_cyc(4);
    xclk = 1'b0; yclk = 1'b0; are = 1'b0; asy = 1'b0;
    wait_cyc(6);
  endtask

  task automatic set_sxy(input logic v);
    sxy = v;
    wait_cyc(4);
  endtask

  task automatic set_cfg(input logic [7:0] v);
    cfg = v;
    wait_cyc(4);
  endtask

  // Event pattern of the seed 0xACE1 (nibbles 1,E,C,A) under cfg 0x88.
  task automatic check_seed_events(input string tag);
    check({tag, "_on"},  {12'd0, on_o},  16'h0001);
    check({tag, "_off"}, {12'd0, off_o}, 16'h000E);
  endtask

  initial begin
    rst_ni = 1'b0;
    asa = 1'b0; are = 1'b0; asy = 1'b0; ynrst = 1'b1; yclk = 1'b0;
    sxy = 1'b0; xclk = 1'b0; xnrst = 1'b1; cfg = 8'h00;
    wait_cyc(3);
    check("rst_xy",    {8'd0, xydata},  16'h0000);
    check("rst_on",    {12'd0, on_o},   16'h0000);
    check("rst_off",   {12'd0, off_o},  16'h0000);
    check("rst_frame", frame_cnt,       16'h0000);
    rst_ni = 1'b1;
    wait_cyc(5);
    check("idle_xy", {8'd0, xydata}, 16'h0000);

    // Seed under ON threshold 8: only nibble 1 fires.
    asa = 1'b1;
    set_cfg(8'h08);
    check("seed_on", {12'd0, on_o}, 16'h0001);

    // One xclk edge: lfsr -> 0x59C3 (nibbles 3,C,9,5); 4-cycle latency.
    xclk = 1'b1;
    wait_cyc(3);
    check("lat_hold_on", {12'd0, on_o}, 16'h0001);
    wait_cyc(1);
    check("lat_new_on",  {12'd0, on_o},  16'h0009);
    check("lat_new_off", {12'd0, off_o}, 16'h0000);
    xclk = 1'b0;
    wait_cyc(6);

    set_cfg(8'h88);
    check("c88_on",  {12'd0, on_o},  16'h0009);
    check("c88_off", {12'd0, off_o}, 16'h0006);

    // Full row sweep: 64 pulses wrap the row and complete one frame.
    for (int k = 1; k <= 64; k++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("row_%0d", k), {8'd0, xydata}, 16'(k % 64));
      if (k == 63) check("frame_before_wrap", frame_cnt, 16'h0000);
      if (k == 64) check("frame_after_wrap",  frame_cnt, 16'h0001);
    end

    // Second xclk advance from 0x59C3 gives 0xB387 (nibbles 7,8,3,B).
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("adv2_on",  {12'd0, on_o},  16'h0005);
    check("adv2_off", {12'd0, off_o}, 16'h000A);

    // are: clears row and col, reloads the seed, frame count kept.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("row_before_are", {8'd0, xydata}, 16'h0001);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("are1_row", {8'd0, xydata}, 16'h0000);
    check_seed_events("are1");
    check("are1_frame", frame_cnt, 16'h0001);
    set_sxy(1'b1);
    check("are1_col", {8'd0, xydata}, 16'h0000);

    // Give row a nonzero value that the column tests must not disturb.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);

    // Column pointer held in reset: xclk ignored, lfsr stays at the seed.
    xnrst = 1'b0;
    wait_cyc(4);
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("xnrst_col_%0d", k), {8'd0, xydata}, 16'h0000);
    end
    set_cfg(8'h0F);
    check("xnrst_on",  {12'd0, on_o},  16'h000F);
    check("xnrst_off", {12'd0, off_o}, 16'h0000);
    set_cfg(8'h88);
    check_seed_events("xnrst");
    xnrst = 1'b1;
    wait_cyc(4);

    // 17 column pulses: 1..15, 0, 1.
    for (int k = 1; k <= 17; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("col_%0d", k), {8'd0, xydata}, 16'(k % 16));
    end
    set_sxy(1'b0);
    check("row_kept", {8'd0, xydata}, 16'h0002);

    // Five more column pulses, then are.
    for (int k = 0; k < 5; k++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    set_sxy(1'b1);
    check("col_before_are", {8'd0, xydata}, 16'h0006);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("are2_col", {8'd0, xydata}, 16'h0000);
    check_seed_events("are2");
    set_sxy(1'b0);
    check("are2_row", {8'd0, xydata}, 16'h0000);

    // asy coincident with xclk: reload wins over the advance.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_asy_on",  {12'd0, on_o},  16'h0009);
    check("pre_asy_off", {12'd0, off_o}, 16'h0006);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check_seed_events("asy_xclk");
    set_sxy(1'b1);
    check("asy_col", {8'd0, xydata}, 16'h0002);

    // asa low: no events, lfsr frozen, col still counts.
    asa = 1'b0;
    set_cfg(8'hFF);
    check("asa0_on",  {12'd0, on_o},  16'h0000);
    check("asa0_off", {12'd0, off_o}, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("asa0_on_%0d", k), {12'd0, on_o}, 16'h0000);
      check($sformatf("asa0_col_%0d", k), {8'd0, xydata}, 16'(2 + k));
    end
    asa = 1'b1;
    set_cfg(8'h88);
    check_seed_events("asa0_frozen");

    // Mid-frame reset clears outputs without waiting for a clock edge.
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_xy",    {8'd0, xydata},  16'h0000);
    check("mid_rst_on",    {12'd0, on_o},   16'h0000);
    check("mid_rst_off",   {12'd0, off_o},  16'h0000);
    check("mid_rst_frame", frame_cnt,       16'h0000);
    wait_cyc(2);
    rst_ni = 1'b1;
    wait_cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
